// File: rtl/rv_pipe_controller_if.sv
// Control-unit <-> datapath bundle: D-stage instruction fields in, stage controls and hazard signals out.
interface rv_pipe_controller_if #(
  parameter int REG_AW = 5
);
  logic [6:0]        opcodeD;
  logic [2:0]        func3D;
  logic [6:0]        func7D;
  logic [REG_AW-1:0] rs1D, rs2D, rdD;
  logic              pcSrcE;
  logic [2:0]        immSrcD;
  logic              regWriteE, memWriteE, ALUSrcE, luiE;
  logic [1:0]        resultSrcE, jumpE;
  logic [2:0]        branchE;
  logic [3:0]        ALUControlE;
  logic              regWriteM, memWriteM;
  logic [1:0]        resultSrcM;
  logic              regWriteW;
  logic [1:0]        resultSrcW;
  logic [REG_AW-1:0] rdW;
  logic [1:0]        forwardAE, forwardBE;
  logic              stallF, stallD, stallE, flushD, flushE, mulDivBusy;

  modport master (
    output opcodeD, func3D, func7D, rs1D, rs2D, rdD, pcSrcE,
    input  immSrcD, regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE, jumpE, branchE,
           ALUControlE, regWriteM, memWriteM, resultSrcM, regWriteW, resultSrcW, rdW,
           forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, mulDivBusy
  );
  modport slave (
    input  opcodeD, func3D, func7D, rs1D, rs2D, rdD, pcSrcE,
    output immSrcD, regWriteE, memWriteE, ALUSrcE, luiE, resultSrcE, jumpE, branchE,
           ALUControlE, regWriteM, memWriteM, resultSrcM, regWriteW, resultSrcW, rdW,
           forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, mulDivBusy
  );
endinterface

// File: rtl/rv_pipe_controller.sv
// 5-stage RISC-V control: D decode, E/M/W control registers, forwarding, load-use/branch hazards, mul/div busy FSM.
module rv_pipe_controller #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_EN  = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  rv_pipe_controller_if.slave bus
);
  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = ($clog2(MAXC) > 0) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  typedef struct packed {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic [1:0] jump;
    logic [2:0] branch;
    logic [3:0] aluCtl;
    logic       aluSrc;
    logic       lui;
  } ctrl_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  ctrl_t             w_decD, r_E;
  logic [2:0]        w_immSrc;
  logic [REG_AW-1:0] r_rdE, r_rs1E, r_rs2E, r_rdM, r_rdW;
  logic              r_regWriteM, r_memWriteM, r_regWriteW;
  logic [1:0]        r_resultSrcM, r_resultSrcW, w_fwdA, w_fwdB;
  logic              w_loadUse, w_stallE, w_stallD, w_flushE, w_flushD, w_enterMd;
  state_t            r_state, w_stateNx;
  logic [CW-1:0]     r_cnt, w_cntNx;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_op = sub ? 4'b0001 : 4'b0000;
      3'b010:  alu_op = 4'b0100;
      3'b100:  alu_op = 4'b0101;
      3'b110:  alu_op = 4'b0011;
      3'b111:  alu_op = 4'b0010;
      default: alu_op = 4'b0000;
    endcase
  endfunction

  always_comb begin
    w_decD   = '0;
    w_immSrc = 3'b000;
    case (bus.opcodeD)
      7'b0110011: begin
        w_decD.regWrite = 1'b1;
        if (MULDIV_EN != 0 && bus.func7D == 7'b0000001 && bus.func3D == 3'b000)
          w_decD.aluCtl = 4'b1000;
        else if (MULDIV_EN != 0 && bus.func7D == 7'b0000001 && bus.func3D == 3'b100)
          w_decD.aluCtl = 4'b1001;
        else if (MULDIV_EN != 0 && bus.func7D == 7'b0000001 && bus.func3D == 3'b110)
          w_decD.aluCtl = 4'b1010;
        else
          w_decD.aluCtl = alu_op(bus.func3D, bus.func7D[5]);
      end
      7'b0010011: begin
        w_decD.regWrite = 1'b1; w_decD.aluSrc = 1'b1;
        w_decD.aluCtl   = alu_op(bus.func3D, 1'b0);
      end
      7'b0000011: begin
        w_decD.regWrite = 1'b1; w_decD.aluSrc = 1'b1; w_decD.resultSrc = 2'b01;
      end
      7'b0100011: begin
        w_decD.memWrite = 1'b1; w_decD.aluSrc = 1'b1; w_immSrc = 3'b001;
      end
      7'b1100011: begin
        w_decD.aluCtl = 4'b0001; w_immSrc = 3'b010;
        case (bus.func3D)
          3'b000:  w_decD.branch = 3'b001;
          3'b001:  w_decD.branch = 3'b010;
          3'b100:  w_decD.branch = 3'b011;
          3'b101:  w_decD.branch = 3'b100;
          default: w_decD.branch = 3'b000;
        endcase
      end
      7'b1101111: begin
        w_decD.regWrite = 1'b1; w_decD.resultSrc = 2'b10; w_decD.jump = 2'b01; w_immSrc = 3'b011;
      end
      7'b1100111: begin
        w_decD.regWrite = 1'b1; w_decD.resultSrc = 2'b10; w_decD.jump = 2'b10; w_decD.aluSrc = 1'b1;
      end
      7'b0110111: begin
        w_decD.regWrite = 1'b1; w_decD.lui = 1'b1; w_decD.aluSrc = 1'b1; w_immSrc = 3'b100;
      end
      default: ;
    endcase
  end

  // Combinational outputs are gated by reset so every output reads 0 while rst is low.
  assign w_loadUse = (r_E.resultSrc == 2'b01) && (r_rdE != '0) && (r_rdE == bus.rs1D || r_rdE == bus.rs2D);
  assign w_stallE  = (r_state == S_BUSY);
  assign w_stallD  = w_loadUse | w_stallE;
  assign w_flushE  = (w_loadUse | bus.pcSrcE) & ~w_stallE & rst;
  assign w_flushD  = bus.pcSrcE & rst;
  assign w_enterMd = ~w_flushE & ~w_stallE & w_decD.aluCtl[3];

  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (r_regWriteM && r_rdM != '0 && r_rdM == r_rs1E)      w_fwdA = 2'b10;
    else if (r_regWriteW && r_rdW != '0 && r_rdW == r_rs1E) w_fwdA = 2'b01;
    if (r_regWriteM && r_rdM != '0 && r_rdM == r_rs2E)      w_fwdB = 2'b10;
    else if (r_regWriteW && r_rdW != '0 && r_rdW == r_rs2E) w_fwdB = 2'b01;
  end

  // The FSM arms on the edge that loads the mul/div into E, so the op is never left unstalled in E.
  always_comb begin
    w_stateNx = r_state;
    w_cntNx   = r_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_stateNx = S_IDLE;
        if (w_enterMd) begin
          w_stateNx = S_BUSY;
          w_cntNx   = (w_decD.aluCtl == 4'b1000) ? MUL_LD : DIV_LD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_stateNx = S_DONE;
        else             w_cntNx   = r_cnt - CW'(1);
      end
      default: w_stateNx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNx;
      r_cnt   <= w_cntNx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_E <= '0; r_rdE <= '0; r_rs1E <= '0; r_rs2E <= '0;
      r_regWriteM <= 1'b0; r_memWriteM <= 1'b0; r_resultSrcM <= '0; r_rdM <= '0;
      r_regWriteW <= 1'b0; r_resultSrcW <= '0; r_rdW <= '0;
    end else begin
      if (w_flushE) begin
        r_E <= '0; r_rdE <= '0; r_rs1E <= '0; r_rs2E <= '0;
      end else if (!w_stallE) begin
        r_E <= w_decD; r_rdE <= bus.rdD; r_rs1E <= bus.rs1D; r_rs2E <= bus.rs2D;
      end
      if (w_stallE) begin
        r_regWriteM <= 1'b0; r_memWriteM <= 1'b0; r_resultSrcM <= '0; r_rdM <= '0;
      end else begin
        r_regWriteM <= r_E.regWrite; r_memWriteM <= r_E.memWrite;
        r_resultSrcM <= r_E.resultSrc; r_rdM <= r_rdE;
      end
      r_regWriteW  <= r_regWriteM;
      r_resultSrcW <= r_resultSrcM;
      r_rdW        <= r_rdM;
    end
  end

  assign bus.immSrcD     = rst ? w_immSrc : 3'b000;
  assign bus.regWriteE   = r_E.regWrite;
  assign bus.memWriteE   = r_E.memWrite;
  assign bus.ALUSrcE     = r_E.aluSrc;
  assign bus.luiE        = r_E.lui;
  assign bus.resultSrcE  = r_E.resultSrc;
  assign bus.jumpE       = r_E.jump;
  assign bus.branchE     = r_E.branch;
  assign bus.ALUControlE = r_E.aluCtl;
  assign bus.regWriteM   = r_regWriteM;
  assign bus.memWriteM   = r_memWriteM;
  assign bus.resultSrcM  = r_resultSrcM;
  assign bus.regWriteW   = r_regWriteW;
  assign bus.resultSrcW  = r_resultSrcW;
  assign bus.rdW         = r_rdW;
  assign bus.forwardAE   = w_fwdA;
  assign bus.forwardBE   = w_fwdB;
  assign bus.stallF      = w_stallD;
  assign bus.stallD      = w_stallD;
  assign bus.stallE      = w_stallE;
  assign bus.flushD      = w_flushD;
  assign bus.flushE      = w_flushE;
  assign bus.mulDivBusy  = w_stallE;
endmodule
